// File: rtl/gray_counter_param_pkg.sv
// Shared Gray/binary conversion helpers and step classification for gray_counter_param.
// Helpers work on a fixed-width word; callers zero-extend inputs and truncate results to WIDTH.
package gray_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_LOAD,
        STEP_INC,
        STEP_DEC
    } step_e;

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Log-step XOR prefix from the MSB down: bit i becomes the XOR of g[MSB:i].
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b = g;
        for (int unsigned s = 1; s < GRAY_MAX_W; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

    function automatic gray_word_t max_val(input int unsigned width);
        return (width >= GRAY_MAX_W) ? '1 : ((gray_word_t'(1) << width) - gray_word_t'(1));
    endfunction

endpackage

// File: rtl/gray_counter_param_if.sv
// Control/status bundle for gray_counter_param.
// The bin signal exists only when GRAY_CNT_BIN_OUT_EN is defined.
interface gray_counter_param_if #(
    parameter int unsigned WIDTH = 4
);
    logic             load_en;
    logic             en;
    logic             up_dn;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
`ifdef GRAY_CNT_BIN_OUT_EN
    logic [WIDTH-1:0] bin;

    modport master (output load_en, en, up_dn, d, input q, tc, wrap, bin);
    modport slave  (input load_en, en, up_dn, d, output q, tc, wrap, bin);
`else
    modport master (output load_en, en, up_dn, d, input q, tc, wrap);
    modport slave  (input load_en, en, up_dn, d, output q, tc, wrap);
`endif
endinterface

// File: rtl/gray_counter_param_gray_to_bin.sv
// Combinational Gray-to-binary converter used to decode the load value.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin = WIDTH'(gray2bin(gray_word_t'(gray)));

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised loadable up/down Gray counter with wrap/saturate mode, tc and wrap flags.
// Define GRAY_CNT_BIN_OUT_EN to expose the registered binary count on bus.bin.
module gray_counter_param
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter bit          SATURATE = 1'b0
) (
    input logic                  clk,
    input logic                  reset,
    gray_counter_param_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_val(WIDTH));
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] d_bin;
    logic             wrap_next;
    step_e            step;

    gray_to_bin #(.WIDTH(WIDTH)) u_d2b (
        .gray (bus.d),
        .bin  (d_bin)
    );

    always_comb begin
        step = STEP_HOLD;
        if (bus.load_en) begin
            step = STEP_LOAD;
        end else if (bus.en) begin
            step = bus.up_dn ? STEP_INC : STEP_DEC;
        end
    end

    always_comb begin
        b_next    = b;
        wrap_next = 1'b0;
        unique case (step)
            STEP_LOAD: b_next = d_bin;
            STEP_INC: begin
                if (b != MAX) begin
                    b_next = b + ONE;
                end else if (!SATURATE) begin
                    b_next    = '0;
                    wrap_next = 1'b1;
                end
            end
            STEP_DEC: begin
                if (b != '0) begin
                    b_next = b - ONE;
                end else if (!SATURATE) begin
                    b_next    = MAX;
                    wrap_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // q is re-encoded from b_next so it is a clean register output; on load this equals d.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b        <= '0;
            bus.q    <= '0;
            bus.wrap <= 1'b0;
        end else begin
            b        <= b_next;
            bus.q    <= WIDTH'(bin2gray(gray_word_t'(b_next)));
            bus.wrap <= wrap_next;
        end
    end

    assign bus.tc = bus.up_dn ? (b == MAX) : (b == '0);

`ifdef GRAY_CNT_BIN_OUT_EN
    assign bus.bin = b;
`endif

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: wrap and saturate 4-bit instances plus a 6-bit wrap instance,
// checked every cycle against an integer count model; bin is checked when GRAY_CNT_BIN_OUT_EN is defined.
module tb_gray_counter_param;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       ld4 = 1'b0, en4 = 1'b0, up4 = 1'b0;
    logic [3:0] d4  = '0;
    logic       ld6 = 1'b0, en6 = 1'b0, up6 = 1'b0;
    logic [5:0] d6  = '0;

    int checks = 0;
    int errors = 0;

    int unsigned wid [3] = '{4, 4, 6};
    bit          sat [3] = '{1'b0, 1'b1, 1'b0};
    int unsigned mv  [3] = '{0, 0, 0};
    bit          mw  [3] = '{0, 0, 0};
    bit          mc  [3] = '{0, 0, 0};
    logic [31:0] prevq [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    gray_counter_param_if #(.WIDTH(4)) bw ();
    gray_counter_param_if #(.WIDTH(4)) bs ();
    gray_counter_param_if #(.WIDTH(6)) b6 ();

    assign bw.load_en = ld4;
    assign bw.en      = en4;
    assign bw.up_dn   = up4;
    assign bw.d       = d4;
    assign bs.load_en = ld4;
    assign bs.en      = en4;
    assign bs.up_dn   = up4;
    assign bs.d       = d4;
    assign b6.load_en = ld6;
    assign b6.en      = en6;
    assign b6.up_dn   = up6;
    assign b6.d       = d6;

    gray_counter_param #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (.clk(clk), .reset(reset), .bus(bw.slave));
    gray_counter_param #(.WIDTH(4), .SATURATE(1'b1)) u_sat  (.clk(clk), .reset(reset), .bus(bs.slave));
    gray_counter_param #(.WIDTH(6), .SATURATE(1'b0)) u_w6   (.clk(clk), .reset(reset), .bus(b6.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer count; a load finds the integer whose Gray image is d.
    task automatic model_step(input int k, input bit ld, input int unsigned dd, input bit e, input bit u);
        int unsigned lim;
        lim   = (1 << wid[k]) - 1;
        mw[k] = 1'b0;
        mc[k] = 1'b0;
        if (ld) begin
            for (int unsigned v = 0; v <= lim; v++) begin
                if ((v ^ (v >> 1)) == dd) mv[k] = v;
            end
        end else if (e) begin
            if (u) begin
                if (mv[k] < lim) begin
                    mv[k]++; mc[k] = 1'b1;
                end else if (!sat[k]) begin
                    mv[k] = 0; mw[k] = 1'b1; mc[k] = 1'b1;
                end
            end else begin
                if (mv[k] > 0) begin
                    mv[k]--; mc[k] = 1'b1;
                end else if (!sat[k]) begin
                    mv[k] = lim; mw[k] = 1'b1; mc[k] = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                mv[k] = 0; mw[k] = 1'b0; mc[k] = 1'b0;
            end
        end else begin
            model_step(0, ld4, 32'(d4), en4, up4);
            model_step(1, ld4, 32'(d4), en4, up4);
            model_step(2, ld6, 32'(d6), en6, up6);
        end
    end

    task automatic cmp(input int k, input logic [31:0] q, input logic tc, input logic wr, input logic u);
        int unsigned lim;
        lim = (1 << wid[k]) - 1;
        chk($sformatf("q[%0d]", k), q, 32'(mv[k] ^ (mv[k] >> 1)));
        chk($sformatf("tc[%0d]", k), 32'(tc), 32'(u ? (mv[k] == lim) : (mv[k] == 0)));
        chk($sformatf("wrap[%0d]", k), 32'(wr), 32'(mw[k]));
        if (mc[k]) chk($sformatf("onebit[%0d]", k), 32'($countones(q ^ prevq[k])), 32'd1);
        prevq[k] = q;
    endtask

    always @(negedge clk) begin
        cmp(0, 32'(bw.q), bw.tc, bw.wrap, up4);
        cmp(1, 32'(bs.q), bs.tc, bs.wrap, up4);
        cmp(2, 32'(b6.q), b6.tc, b6.wrap, up6);
`ifdef GRAY_CNT_BIN_OUT_EN
        chk("bin[0]", 32'(bw.bin), 32'(mv[0]));
        chk("bin[1]", 32'(bs.bin), 32'(mv[1]));
        chk("bin[2]", 32'(b6.bin), 32'(mv[2]));
`endif
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        chk("rst_q_w", 32'(bw.q), 32'h0);
        chk("rst_q_s", 32'(bs.q), 32'h0);
        chk("rst_q_6", 32'(b6.q), 32'h0);
        chk("rst_wrap", 32'(bw.wrap), 32'h0);
        @(negedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_q", 32'(bw.q), 32'h0);
        end

        // Load 0011 then count up
        ld4 = 1'b1; d4 = 4'b0011;
        step(); chk("ld_0011", 32'(bw.q), 32'b0011);
        ld4 = 1'b0; en4 = 1'b1; up4 = 1'b1;
        step(); chk("up_0010", 32'(bw.q), 32'b0010);
        step(); chk("up_0110", 32'(bw.q), 32'b0110);
        step(); chk("up_0111", 32'(bw.q), 32'b0111);

        // Upward limit: wrap instance wraps once, saturate instance holds
        en4 = 1'b0; ld4 = 1'b1; d4 = 4'b1000;
        step(); chk("ld_1000_w", 32'(bw.q), 32'b1000); chk("ld_1000_s", 32'(bs.q), 32'b1000);
        ld4 = 1'b0; en4 = 1'b1; up4 = 1'b1;
        step();
        chk("wrap_q", 32'(bw.q), 32'b0000); chk("wrap_pulse", 32'(bw.wrap), 32'h1);
        chk("sat_q1", 32'(bs.q), 32'b1000); chk("sat_tc1", 32'(bs.tc), 32'h1); chk("sat_wr1", 32'(bs.wrap), 32'h0);
        step();
        chk("wrap_q2", 32'(bw.q), 32'b0001); chk("wrap_end", 32'(bw.wrap), 32'h0);
        chk("sat_q2", 32'(bs.q), 32'b1000); chk("sat_tc2", 32'(bs.tc), 32'h1);
        step();
        chk("sat_q3", 32'(bs.q), 32'b1000); chk("sat_wr3", 32'(bs.wrap), 32'h0);
        up4 = 1'b0;
        #1 chk("sat_tc_dn", 32'(bs.tc), 32'h0);
        step(); chk("sat_dn_q", 32'(bs.q), 32'b1001);

        // Downward wrap from 0
        en4 = 1'b0; ld4 = 1'b1; d4 = 4'b0000;
        step();
        ld4 = 1'b0; en4 = 1'b1; up4 = 1'b0;
        step();
        chk("dnwrap_q", 32'(bw.q), 32'b1000); chk("dnwrap_pulse", 32'(bw.wrap), 32'h1);
        chk("sat0_q", 32'(bs.q), 32'b0000); chk("sat0_tc", 32'(bs.tc), 32'h1);

        // Load has priority over count
        ld4 = 1'b1; en4 = 1'b1; up4 = 1'b1; d4 = 4'b0101;
        step(); chk("ld_wins", 32'(bw.q), 32'b0101); chk("ld_nowrap", 32'(bw.wrap), 32'h0);

        // Reset mid-count
        ld4 = 1'b0;
        step();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_q_w", 32'(bw.q), 32'h0);
        chk("midrst_q_s", 32'(bs.q), 32'h0);
        @(negedge clk);
        #1 reset = 1'b0;

        // Randomised run on all instances
        for (int i = 0; i < 400; i++) begin
            ld4 = ($urandom_range(0, 7) == 0);
            en4 = ($urandom_range(0, 3) != 0);
            up4 = 1'($urandom_range(0, 1));
            d4  = 4'($urandom);
            ld6 = ($urandom_range(0, 7) == 0);
            en6 = ($urandom_range(0, 3) != 0);
            up6 = 1'($urandom_range(0, 1));
            d6  = 6'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
